// File: rtl/bmp_header_parser.sv
// Reads the 54-byte BMP file header and DIB header from byte-wide memory,
// decodes the geometry fields and reports the first failing sanity check.
module bmp_header_parser #(
  parameter logic [23:0] BASE_ADDR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic [23:0] addr,
  output logic        rden,
  input  logic [7:0]  rddata,
  output logic [31:0] width,
  output logic [31:0] height,
  output logic [31:0] file_size,
  output logic [31:0] data_offset,
  output logic [15:0] bpp,
  output logic [2:0]  error,
  output logic        valid
);

  localparam int unsigned AW         = 24;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned HDR_BYTES  = 54;
  // Bytes past the compression field are read but never inspected.
  localparam int unsigned USED_BYTES = 34;
  localparam int unsigned MIN_OFFSET = 54;

  localparam logic [2:0] ERR_OK     = 3'd0;
  localparam logic [2:0] ERR_SIG    = 3'd1;
  localparam logic [2:0] ERR_DIB    = 3'd2;
  localparam logic [2:0] ERR_PLANES = 3'd3;
  localparam logic [2:0] ERR_BPP    = 3'd4;
  localparam logic [2:0] ERR_COMP   = 3'd5;
  localparam logic [2:0] ERR_OFFSET = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cap_en;
  logic [CNT_W-1:0] cap_idx;
  logic [7:0]       hdr [USED_BYTES];

  logic [15:0] sig_c;
  logic [31:0] file_size_c;
  logic [31:0] data_offset_c;
  logic [31:0] dib_size_c;
  logic [31:0] width_c;
  logic [31:0] height_c;
  logic [15:0] planes_c;
  logic [15:0] bpp_c;
  logic [31:0] compression_c;
  logic [2:0]  error_c;

  // Little-endian field extraction from the captured header bytes.
  assign sig_c         = {hdr[1],  hdr[0]};
  assign file_size_c   = {hdr[5],  hdr[4],  hdr[3],  hdr[2]};
  assign data_offset_c = {hdr[13], hdr[12], hdr[11], hdr[10]};
  assign dib_size_c    = {hdr[17], hdr[16], hdr[15], hdr[14]};
  assign width_c       = {hdr[21], hdr[20], hdr[19], hdr[18]};
  assign height_c      = {hdr[25], hdr[24], hdr[23], hdr[22]};
  assign planes_c      = {hdr[27], hdr[26]};
  assign bpp_c         = {hdr[29], hdr[28]};
  assign compression_c = {hdr[33], hdr[32], hdr[31], hdr[30]};

  // Priority-ordered checks: the lowest failing code wins.
  always_comb begin
    error_c = ERR_OK;
    if (sig_c != 16'h4D42)
      error_c = ERR_SIG;
    else if (dib_size_c != 32'd40)
      error_c = ERR_DIB;
    else if (planes_c != 16'd1)
      error_c = ERR_PLANES;
    else if (bpp_c != 16'd24)
      error_c = ERR_BPP;
    else if (compression_c != 32'd0)
      error_c = ERR_COMP;
    else if (data_offset_c < 32'(MIN_OFFSET))
      error_c = ERR_OFFSET;
  end

  // Control FSM; memory returns data one cycle after rden, so capture lags by one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_en      <= 1'b0;
      cap_idx     <= '0;
      rden        <= 1'b0;
      addr        <= '0;
      done        <= 1'b0;
      valid       <= 1'b0;
      width       <= '0;
      height      <= '0;
      file_size   <= '0;
      data_offset <= '0;
      bpp         <= '0;
      error       <= '0;
    end else begin
      cap_en  <= rden;
      cap_idx <= cnt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= READ;
            cnt   <= '0;
            rden  <= 1'b1;
            addr  <= BASE_ADDR;
            done  <= 1'b0;
          end
        end
        READ: begin
          if (cnt == CNT_W'(HDR_BYTES - 1)) begin
            state <= DRAIN;
            rden  <= 1'b0;
            addr  <= '0;
          end else begin
            cnt  <= cnt + CNT_W'(1);
            addr <= BASE_ADDR + AW'(cnt) + AW'(1);
          end
        end
        DRAIN: begin
          state <= CHECK;
        end
        CHECK: begin
          state       <= DONE;
          done        <= 1'b1;
          width       <= width_c;
          height      <= height_c;
          file_size   <= file_size_c;
          data_offset <= data_offset_c;
          bpp         <= bpp_c;
          error       <= error_c;
          valid       <= (error_c == ERR_OK);
        end
        default: begin
          state <= IDLE;
          rden  <= 1'b0;
          addr  <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Header byte store; contents are only consumed after a complete read.
  always_ff @(posedge clk) begin
    if (cap_en && (cap_idx < CNT_W'(USED_BYTES)))
      hdr[cap_idx] <= rddata;
  end

endmodule

// File: tb/tb_bmp_header_parser.sv
// Randomized scoreboard bench for bmp_header_parser: two instances at different
// base addresses share one byte memory; a monitor checks results as done rises.
module tb_bmp_header_parser;

  localparam logic [23:0] BASE1 = 24'h000100;

  typedef struct {
    logic [7:0]  s0, s1;
    logic [31:0] fsize, off, dib, w, h, comp;
    logic [15:0] planes, bpp;
  } hdr_t;

  typedef struct {
    logic [31:0] w, h, fsize, off;
    logic [15:0] bpp;
    logic [2:0]  err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  mem [64];
  logic [7:0]  rd0, rd1;
  logic [23:0] off1;

  logic        done0, rden0, valid0, done1, rden1, valid1;
  logic [23:0] addr0, addr1;
  logic [31:0] width0, height0, fsize0, doff0, width1, height1, fsize1, doff1;
  logic [15:0] bpp0, bpp1;
  logic [2:0]  error0, error1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last_exp;
  bit   done0_prev = 1'b0;

  bmp_header_parser #(.BASE_ADDR(24'h000000)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done0), .addr(addr0),
    .rden(rden0), .rddata(rd0), .width(width0), .height(height0),
    .file_size(fsize0), .data_offset(doff0), .bpp(bpp0), .error(error0),
    .valid(valid0)
  );

  bmp_header_parser #(.BASE_ADDR(BASE1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done1), .addr(addr1),
    .rden(rden1), .rddata(rd1), .width(width1), .height(height1),
    .file_size(fsize1), .data_offset(doff1), .bpp(bpp1), .error(error1),
    .valid(valid1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte memory: data appears the cycle after the read strobe.
  assign off1 = addr1 - BASE1;
  always @(posedge clk) begin
    if (rden0) rd0 <= mem[addr0[5:0]];
    if (rden1) rd1 <= mem[off1[5:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected decode straight from the header fields that were written.
  function automatic exp_t model(input hdr_t f);
    exp_t e;
    e.w = f.w; e.h = f.h; e.fsize = f.fsize; e.off = f.off; e.bpp = f.bpp;
    if (f.s0 != 8'd66 || f.s1 != 8'd77) e.err = 3'd1;
    else if (f.dib != 40)               e.err = 3'd2;
    else if (f.planes != 1)             e.err = 3'd3;
    else if (f.bpp != 24)               e.err = 3'd4;
    else if (f.comp != 0)               e.err = 3'd5;
    else if (f.off < 54)                e.err = 3'd6;
    else                                e.err = 3'd0;
    e.due = 0;
    return e;
  endfunction

  function automatic hdr_t good_hdr(input logic [31:0] w, input logic [31:0] h);
    hdr_t f;
    f.s0 = 8'd66; f.s1 = 8'd77; f.fsize = 32'd54 + w * h * 32'd3;
    f.off = 32'd54; f.dib = 32'd40; f.w = w; f.h = h;
    f.planes = 16'd1; f.bpp = 16'd24; f.comp = 32'd0;
    return f;
  endfunction

  task automatic put(input int a, input int n, input logic [31:0] v);
    for (int b = 0; b < n; b++) mem[a + b] = 8'(v >> (8 * b));
  endtask

  task automatic load_hdr(input hdr_t f);
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[0] = f.s0;
    mem[1] = f.s1;
    put(2, 4, f.fsize);
    put(10, 4, f.off);
    put(14, 4, f.dib);
    put(18, 4, f.w);
    put(22, 4, f.h);
    put(26, 2, 32'(f.planes));
    put(28, 2, 32'(f.bpp));
    put(30, 4, f.comp);
  endtask

  // One full parse; hold keeps start high through READ, pulse_k pulses it once.
  task automatic run_parse(input hdr_t f, input bit hold, input int pulse_k);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    e = model(f);
    e.due = cyc + 57;
    sb.push_back(e);
    for (int k = 0; k < 54; k++) begin
      @(negedge clk);
      if (!hold) start = (k == pulse_k);
      chk("rden_read", 32'(rden0), 32'd1);
      chk("addr_read", 32'(addr0), 32'(k));
      chk("addr_read_base", 32'(addr1), 32'(BASE1) + 32'(k));
      chk("done_read", 32'(done0), 32'd0);
      chk("width_hold", width0, last_exp.w);
      chk("error_hold", 32'(error0), 32'(last_exp.err));
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("rden_tail", 32'({rden0, rden1}), 32'd0);
      chk("addr_tail", 32'(addr0), 32'd0);
      chk("done_tail", 32'(done0), 32'd0);
      chk("bpp_hold", 32'(bpp0), 32'(last_exp.bpp));
    end
    for (int i = 0; i < 8 && !done0; i++) @(negedge clk);
    if (!done0) begin
      errors++;
      $display("FAIL done_timeout: done still %0b after parse", done0);
    end
    chk("rden_done", 32'(rden0), 32'd0);
    last_exp = e;
  endtask

  // Scoreboard monitor: each rising done retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0 && !done0_prev) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done rose with empty scoreboard");
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.due));
          chk("width", width0, e.w);
          chk("height", height0, e.h);
          chk("file_size", fsize0, e.fsize);
          chk("data_offset", doff0, e.off);
          chk("bpp", 32'(bpp0), 32'(e.bpp));
          chk("error", 32'(error0), 32'(e.err));
          chk("valid", 32'(valid0), 32'(e.err == 3'd0));
          chk("done_base", 32'(done1), 32'd1);
          chk("width_base", width1, e.w);
          chk("height_base", height1, e.h);
          chk("fsize_base", fsize1, e.fsize);
          chk("doff_base", doff1, e.off);
          chk("bpp_base", 32'(bpp1), 32'(e.bpp));
          chk("error_base", 32'(error1), 32'(e.err));
          chk("valid_base", 32'(valid1), 32'(e.err == 3'd0));
        end
      end
      done0_prev = done0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_done"}, 32'({done0, done1}), 32'd0);
    chk({tag, "_rden"}, 32'({rden0, rden1}), 32'd0);
    chk({tag, "_addr"}, 32'(addr0 | addr1), 32'd0);
    chk({tag, "_valid"}, 32'({valid0, valid1}), 32'd0);
    chk({tag, "_width"}, width0 | width1, 32'd0);
    chk({tag, "_height"}, height0 | height1, 32'd0);
    chk({tag, "_fsize"}, fsize0 | fsize1, 32'd0);
    chk({tag, "_doff"}, doff0 | doff1, 32'd0);
    chk({tag, "_bpp"}, 32'(bpp0 | bpp1), 32'd0);
    chk({tag, "_error"}, 32'(error0 | error1), 32'd0);
  endtask

  initial begin
    hdr_t f;
    rst_n = 1'b0;
    start = 1'b0;
    last_exp = '{default: '0};
    load_hdr(good_hdr(32'd100, 32'd100));
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Reference 100x100 24-bpp header, then a start pulse ignored mid-READ.
    f = good_hdr(32'd100, 32'd100);
    chk("model_fsize_ref", f.fsize, 32'd30054);
    load_hdr(f);
    run_parse(f, 1'b0, 30);

    // Bad signature outranks bad bpp.
    f.s1 = 8'd78; f.bpp = 16'd32;
    load_hdr(f);
    run_parse(f, 1'b0, -1);

    f = good_hdr(32'd100, 32'd100); f.bpp = 16'd32;
    load_hdr(f);
    run_parse(f, 1'b0, 10);

    f = good_hdr(32'd100, 32'd100); f.off = 32'd40;
    load_hdr(f);
    run_parse(f, 1'b0, -1);

    // Reset at cycle 20 aborts, then a full re-parse of the reference header.
    f = good_hdr(32'd100, 32'd100);
    load_hdr(f);
    @(negedge clk);
    start = 1'b1;
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("abort");
    last_exp = '{default: '0};
    run_parse(f, 1'b0, -1);

    // Start held high from DONE with a new 200x50 header.
    f = good_hdr(32'd200, 32'd50);
    load_hdr(f);
    run_parse(f, 1'b1, -1);

    // Random headers with random single or multiple field corruptions.
    for (int n = 0; n < 8; n++) begin
      f = good_hdr($urandom_range(1, 4000), $urandom_range(1, 4000));
      f.fsize = $urandom;
      if ($urandom_range(0, 4) == 0) f.s0 = 8'($urandom_range(0, 65));
      if ($urandom_range(0, 4) == 0) f.s1 = 8'($urandom_range(78, 255));
      if ($urandom_range(0, 4) == 0) f.dib = $urandom_range(41, 200);
      if ($urandom_range(0, 4) == 0) f.planes = 16'($urandom_range(2, 9));
      if ($urandom_range(0, 3) == 0) f.bpp = 16'($urandom_range(0, 23));
      if ($urandom_range(0, 4) == 0) f.comp = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) f.off = $urandom_range(0, 53);
      else f.off = $urandom_range(54, 5000);
      load_hdr(f);
      run_parse(f, 1'b0, $urandom_range(0, 60));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
